// File: rtl/wb_commit_stage_if.sv
// Memory-stage to write-back-stage bundle handshake.
// A bundle transfers on a rising clk edge where ms_to_ws_valid && ws_allowin are both 1.
// The master holds valid and bus stable until that edge. ws_allowin never depends on
// ms_to_ws_valid, so there is no combinational loop through the handshake.
interface wb_commit_stage_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32
);
  localparam int LANE_W = 43 + 2 * DATA_W;

  logic                      ms_to_ws_valid;
  logic [LANES*LANE_W-1:0]   ms_to_ws_bus;
  logic                      ws_allowin;

  modport master (output ms_to_ws_valid, output ms_to_ws_bus, input ws_allowin);
  modport slave  (input ms_to_ws_valid, input ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_commit_stage.sv
// Write-back commit stage: holds one multi-lane bundle and retires one lane per cycle
// through a single register-file write port, in ascending lane order.
module wb_commit_stage #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  wb_commit_stage_if.slave  ms_ws,
  output logic [3:0]        rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              send_flush,
  output logic              exc_valid,
  output logic              eret_valid,
  output logic [DATA_W-1:0] exc_pc,
  output logic              fwd_valid,
  output logic [4:0]        fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);
  // Lane fields are right-aligned in each lane slot; bits above lane_valid are reserved.
  localparam int LANE_W   = 43 + 2 * DATA_W;
  localparam int BUS_W    = LANES * LANE_W;
  localparam int RES_LSB  = DATA_W;
  localparam int DEST_LSB = 2 * DATA_W;
  localparam int WE_LSB   = 2 * DATA_W + 5;
  localparam int ERET_BIT = 2 * DATA_W + 9;
  localparam int EXC_BIT  = 2 * DATA_W + 10;
  localparam int LV_BIT   = 2 * DATA_W + 11;

  logic [BUS_W-1:0]  bus_q;
  logic              ws_valid;
  logic [LANES-1:0]  pending;
  logic [LANE_W-1:0] cur_lane;
  logic              cur_hit;
  logic [LANES-1:0]  cur_onehot;
  logic [LANES-1:0]  lane_valid_bits;
  logic              seen_one;
  logic              more_than_one;
  logic              cur_exc;
  logic              cur_eret;
  logic              cur_kill;
  logic              ws_ready_go;
  logic              allowin;
  logic              accept;
  logic              unused_lane_bits;

  // Current lane is the lowest-index pending lane; invalid lanes never enter pending.
  always_comb begin
    cur_lane   = '0;
    cur_hit    = 1'b0;
    cur_onehot = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (pending[k]) begin
        cur_lane      = bus_q[k*LANE_W +: LANE_W];
        cur_hit       = 1'b1;
        cur_onehot    = '0;
        cur_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seen_one      = 1'b0;
    more_than_one = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (pending[k]) begin
        if (seen_one) more_than_one = 1'b1;
        seen_one = 1'b1;
      end
    end
  end

  always_comb begin
    lane_valid_bits = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_valid_bits[k] = ms_ws.ms_to_ws_bus[k*LANE_W + LV_BIT];
    end
  end

  // Exception wins over eret when a lane carries both.
  assign cur_exc  = cur_hit & cur_lane[EXC_BIT];
  assign cur_eret = cur_hit & cur_lane[ERET_BIT] & ~cur_lane[EXC_BIT];
  assign cur_kill = cur_exc | cur_eret;

  assign ws_ready_go    = !more_than_one || cur_kill;
  assign allowin        = !ws_valid || ws_ready_go;
  assign ms_ws.ws_allowin = allowin;
  assign accept         = ms_ws.ms_to_ws_valid && allowin;

  assign rf_we      = (ws_valid && cur_hit && !cur_kill) ? cur_lane[WE_LSB +: 4] : 4'b0;
  assign rf_waddr   = cur_lane[DEST_LSB +: 5];
  assign rf_wdata   = cur_lane[RES_LSB +: DATA_W];
  assign send_flush = ws_valid & cur_kill;
  assign exc_valid  = ws_valid & cur_exc;
  assign eret_valid = ws_valid & cur_eret;
  assign exc_pc     = cur_lane[DATA_W-1:0];

  assign fwd_valid = |rf_we;
  assign fwd_dest  = rf_waddr;
  assign fwd_data  = rf_wdata;

  assign debug_wb_pc       = cur_lane[DATA_W-1:0];
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  assign unused_lane_bits = ^cur_lane[LANE_W-1:LV_BIT];

  // Control state; a kill or the last pending lane retires the bundle in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid <= 1'b0;
      pending  <= '0;
    end else if (flush) begin
      ws_valid <= 1'b0;
      pending  <= '0;
    end else if (accept) begin
      ws_valid <= 1'b1;
      pending  <= lane_valid_bits;
    end else if (ws_valid) begin
      if (ws_ready_go) begin
        ws_valid <= 1'b0;
        pending  <= '0;
      end else begin
        pending <= pending & ~cur_onehot;
      end
    end
  end

  // Payload is left unreset; every output is gated by ws_valid/pending.
  always_ff @(posedge clk) begin
    if (accept) bus_q <= ms_ws.ms_to_ws_bus;
  end
endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed bundles plus a random stream, checked against
// a commit-event queue model built from each accepted bundle.
module tb_wb_commit_stage;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int LANE_W = 43 + 2 * DATA_W;
  localparam int PAD    = LANE_W - 12 - 2 * DATA_W;
  localparam int BUS_W  = LANES * LANE_W;
  localparam int EV_W   = 2 + 4 + 5 + 2 * DATA_W;
  localparam logic [1:0] K_IDLE = 2'd0, K_WR = 2'd1, K_EXC = 2'd2, K_ERET = 2'd3;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [3:0]        rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              send_flush;
  logic              exc_valid;
  logic              eret_valid;
  logic [DATA_W-1:0] exc_pc;
  logic              fwd_valid;
  logic [4:0]        fwd_dest;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  wb_commit_stage_if #(.LANES(LANES), .DATA_W(DATA_W)) ms_ws ();

  wb_commit_stage #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .ms_ws             (ms_ws),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .send_flush        (send_flush),
    .exc_valid         (exc_valid),
    .eret_valid        (eret_valid),
    .exc_pc            (exc_pc),
    .fwd_valid         (fwd_valid),
    .fwd_dest          (fwd_dest),
    .fwd_data          (fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: one entry per expected commit cycle of the held bundle
  logic [EV_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [LANE_W-1:0] mk_lane(input logic v, input logic e, input logic r,
                                                input logic [3:0] we, input logic [4:0] d,
                                                input logic [DATA_W-1:0] res,
                                                input logic [DATA_W-1:0] pc);
    return {{PAD{1'b0}}, v, e, r, we, d, res, pc};
  endfunction

  function automatic logic [LANE_W-1:0] rand_lane();
    return mk_lane($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                   5'($urandom_range(0, 31)), $urandom, $urandom);
  endfunction

  // Walk lanes oldest-first: invalid lanes vanish, an exc/eret lane is the last event.
  task automatic model_load(input logic [BUS_W-1:0] bus);
    logic [PAD-1:0]    pad;
    logic              v, e, r;
    logic [3:0]        we;
    logic [4:0]        d;
    logic [DATA_W-1:0] res, pc;
    bit                stop;
    stop = 0;
    exp_q.delete();
    for (int k = 0; k < LANES; k++) begin
      {pad, v, e, r, we, d, res, pc} = bus[k*LANE_W +: LANE_W];
      if (!stop && v) begin
        if (e) begin
          exp_q.push_back({K_EXC, 4'd0, d, res, pc});
          stop = 1;
        end else if (r) begin
          exp_q.push_back({K_ERET, 4'd0, d, res, pc});
          stop = 1;
        end else begin
          exp_q.push_back({K_WR, we, d, res, pc});
        end
      end
    end
    if (exp_q.size() == 0) exp_q.push_back({K_IDLE, 4'd0, 5'd0, {DATA_W{1'b0}}, {DATA_W{1'b0}}});
  endtask

  task automatic check_outputs();
    logic [1:0]        kind;
    logic [3:0]        we;
    logic [4:0]        d;
    logic [DATA_W-1:0] res, pc;
    if (exp_q.size() == 0) begin
      check("allowin_empty", ms_ws.ws_allowin, 1);
      check("rf_we_empty", rf_we, 0);
      check("send_flush_empty", send_flush, 0);
      check("exc_valid_empty", exc_valid, 0);
      check("eret_valid_empty", eret_valid, 0);
      check("fwd_valid_empty", fwd_valid, 0);
    end else begin
      {kind, we, d, res, pc} = exp_q[0];
      check("allowin", ms_ws.ws_allowin, exp_q.size() == 1);
      check("rf_we", rf_we, we);
      check("dbg_wen", debug_wb_rf_wen, we);
      check("fwd_valid", fwd_valid, we != 0);
      check("send_flush", send_flush, kind == K_EXC || kind == K_ERET);
      check("exc_valid", exc_valid, kind == K_EXC);
      check("eret_valid", eret_valid, kind == K_ERET);
      if (kind == K_WR || kind == K_EXC || kind == K_ERET) check("dbg_pc", debug_wb_pc, pc);
      if (kind == K_EXC || kind == K_ERET) check("exc_pc", exc_pc, pc);
      if (kind == K_WR && we != 0) begin
        check("rf_waddr", rf_waddr, d);
        check("rf_wdata", rf_wdata, res);
        check("fwd_dest", fwd_dest, d);
        check("fwd_data", fwd_data, res);
        check("dbg_wnum", debug_wb_rf_wnum, d);
        check("dbg_wdata", debug_wb_rf_wdata, res);
      end
    end
  endtask

  // Driver: check the current cycle, drive inputs, advance one clock with the model
  task automatic cycle(input logic v, input logic [BUS_W-1:0] bus, input logic fl);
    bit acc;
    check_outputs();
    ms_ws.ms_to_ws_valid = v;
    ms_ws.ms_to_ws_bus   = bus;
    flush                = fl;
    acc = v && (exp_q.size() <= 1);
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) model_load(bus);
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  logic [BUS_W-1:0] b37, b38, b39, b40, bus_r;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    ms_ws.ms_to_ws_valid = 1'b0;
    ms_ws.ms_to_ws_bus   = '0;
    #1 reset = 1'b1;
    #1 check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Two plain writes
    b37 = {mk_lane(1, 0, 0, 4'hF, 5'd4, 32'h22, 32'h104), mk_lane(1, 0, 0, 4'hF, 5'd3, 32'h11, 32'h100)};
    cycle(1, b37, 0);
    check("r37_c1", {rf_we, rf_waddr, rf_wdata, ms_ws.ws_allowin}, {4'hF, 5'd3, 32'h11, 1'b0});
    cycle(0, '0, 0);
    check("r37_c2", {rf_we, rf_waddr, rf_wdata, ms_ws.ws_allowin}, {4'hF, 5'd4, 32'h22, 1'b1});
    cycle(0, '0, 0);

    // Older write, then younger exception
    b38 = {mk_lane(1, 1, 0, 4'hF, 5'd9, 32'h33, 32'hBFC00380), mk_lane(1, 0, 0, 4'hF, 5'd5, 32'h55, 32'h200)};
    cycle(1, b38, 0);
    check("r38_c1", {rf_we, rf_waddr}, {4'hF, 5'd5});
    cycle(0, '0, 0);
    check("r38_c2", {send_flush, exc_valid, rf_we, exc_pc}, {1'b1, 1'b1, 4'h0, 32'hBFC00380});
    cycle(0, '0, 0);

    // Exception on lane 0 kills lane 1
    b39 = {mk_lane(1, 0, 0, 4'hF, 5'd6, 32'h66, 32'h304), mk_lane(1, 1, 1, 4'hF, 5'd2, 32'h77, 32'h300)};
    cycle(1, b39, 0);
    check("r39_c1", {send_flush, exc_valid, eret_valid, rf_we, ms_ws.ws_allowin}, {1'b1, 1'b1, 1'b0, 4'h0, 1'b1});
    cycle(0, '0, 0);

    // Invalid lane 0 skipped in zero cycles
    b40 = {mk_lane(1, 0, 0, 4'h3, 5'd7, 32'h88, 32'h404), mk_lane(0, 0, 0, 4'hF, 5'd1, 32'h99, 32'h400)};
    cycle(1, b40, 0);
    check("r40_c1", {rf_we, rf_waddr, ms_ws.ws_allowin}, {4'h3, 5'd7, 1'b1});
    cycle(0, '0, 0);

    // Flush coinciding with accept
    cycle(1, b37, 1);
    check("r41_flush", {rf_we, send_flush, ms_ws.ws_allowin}, {4'h0, 1'b0, 1'b1});
    cycle(0, '0, 0);

    // Asynchronous reset mid-bundle
    cycle(1, b37, 0);
    check_outputs();
    ms_ws.ms_to_ws_valid = 1'b0;
    #1 reset = 1'b1;
    #1 exp_q.delete();
    check("r41_rst_we", rf_we, 0);
    check_outputs();
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cycle(0, '0, 0);

    // Random stream, including back-to-back bundles and flushes
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < LANES; k++) bus_r[k*LANE_W +: LANE_W] = rand_lane();
      cycle($urandom_range(0, 3) != 0, bus_r, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
